// File: rtl/shift_reg_param_sipo_framed.sv
// shift_reg_param_sipo_framed
// WIDTH-bit serial/parallel shift register with selectable shift direction,
// parallel load and synchronous clear. A bit counter raises a registered
// one-cycle o_valid pulse each time WIDTH bits have been shifted in since
// the last reset, load, clear or completed word.
// WIDTH is meaningful from 2 to 32.

module shift_reg_param_sipo_framed #(
  parameter  int WIDTH     = 8,
  parameter  bit MSB_FIRST = 1'b0,
  localparam int CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,    // synchronous, active-low
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic             i_SD,
  input  logic [WIDTH-1:0] i_D,
  output logic             o_SD,
  output logic [WIDTH-1:0] o_Q,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_valid
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_SHIFT = 2'b01;
  localparam logic [1:0] MODE_LOAD  = 2'b10;
  localparam logic [1:0] MODE_CLEAR = 2'b11;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] r_cnt;
  logic             r_valid;

  logic [WIDTH-1:0] w_shift_q;
  logic             w_serial_out;
  logic             w_cnt_last;

  // Direction is fixed at build time: pick the shift network and the
  // serial output end once, so no mux is left in the datapath.
  generate
    if (MSB_FIRST) begin : g_toward_lsb
      assign w_shift_q    = {i_SD, r_q[WIDTH-1:1]};
      assign w_serial_out = r_q[0];
    end else begin : g_toward_msb
      assign w_shift_q    = {r_q[WIDTH-2:0], i_SD};
      assign w_serial_out = r_q[WIDTH-1];
    end
  endgenerate

  // The shift that completes a word is the one taken while cnt sits at WIDTH-1.
  assign w_cnt_last = (r_cnt == CNT_LAST);

  // Register, counter and word pulse; reset outranks enable and mode.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_q     <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else if (i_en) begin
      case (i_mode)
        MODE_SHIFT: begin
          r_q <= w_shift_q;
          if (w_cnt_last) begin
            r_cnt   <= '0;
            r_valid <= 1'b1;
          end else begin
            r_cnt   <= r_cnt + CNT_ONE;
            r_valid <= 1'b0;
          end
        end
        MODE_LOAD: begin
          r_q     <= i_D;
          r_cnt   <= '0;
          r_valid <= 1'b0;
        end
        MODE_CLEAR: begin
          r_q     <= '0;
          r_cnt   <= '0;
          r_valid <= 1'b0;
        end
        default: begin
          // MODE_HOLD: keep word and count, drop the pulse
          r_valid <= 1'b0;
        end
      endcase
    end else begin
      r_valid <= 1'b0;
    end
  end

  // Outputs come straight from flops: no combinational path from inputs.
  assign o_Q     = r_q;
  assign o_SD    = w_serial_out;
  assign o_cnt   = r_cnt;
  assign o_valid = r_valid;

endmodule

// File: tb/tb_shift_reg_param_sipo_framed.sv
// Bench for shift_reg_param_sipo_framed: three builds (8/LSB-in, 8/MSB-in,
// 5/LSB-in) share one stimulus; a word-level model is compared every cycle,
// plus literal expectations from the directed scenarios.

module tb_shift_reg_param_sipo_framed;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_en;
  logic [1:0] i_mode;
  logic       i_SD;
  logic [7:0] i_D;

  logic [7:0] q0, q1;
  logic [4:0] q2;
  logic [3:0] cnt0, cnt1;
  logic [2:0] cnt2;
  logic       sd0, sd1, sd2;
  logic       v0, v1, v2;

  always #5 i_clk = ~i_clk;

  shift_reg_param_sipo_framed #(.WIDTH(8), .MSB_FIRST(1'b0)) dut0 (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_mode(i_mode), .i_SD(i_SD),
    .i_D(i_D), .o_SD(sd0), .o_Q(q0), .o_cnt(cnt0), .o_valid(v0));

  shift_reg_param_sipo_framed #(.WIDTH(8), .MSB_FIRST(1'b1)) dut1 (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_mode(i_mode), .i_SD(i_SD),
    .i_D(i_D), .o_SD(sd1), .o_Q(q1), .o_cnt(cnt1), .o_valid(v1));

  shift_reg_param_sipo_framed #(.WIDTH(5), .MSB_FIRST(1'b0)) dut2 (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_mode(i_mode), .i_SD(i_SD),
    .i_D(i_D[4:0]), .o_SD(sd2), .o_Q(q2), .o_cnt(cnt2), .o_valid(v2));

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- word-level model ----------------
  function automatic int wof(input int k);
    return (k == 2) ? 5 : 8;
  endfunction

  function automatic bit mof(input int k);
    return (k == 1);
  endfunction

  function automatic logic [31:0] maskof(input int k);
    return (32'd1 << wof(k)) - 32'd1;
  endfunction

  // New bit enters at the LSB (value doubles) or at the MSB (value halves).
  function automatic logic [31:0] shifted(input logic [31:0] q, input int k, input logic sd);
    if (mof(k))
      return (q >> 1) | ({31'd0, sd} << (wof(k) - 1));
    else
      return ((q << 1) | {31'd0, sd}) & maskof(k);
  endfunction

  logic [31:0] m_q [3];
  int          m_n [3];   // shifts since last restart, unbounded
  logic        m_v [3];

  always @(posedge i_clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!i_rst) begin
        m_q[k] <= 32'd0; m_n[k] <= 0; m_v[k] <= 1'b0;
      end else if (i_en && i_mode == 2'b01) begin
        m_q[k] <= shifted(m_q[k], k, i_SD);
        m_n[k] <= m_n[k] + 1;
        m_v[k] <= ((m_n[k] + 1) % wof(k)) == 0;
      end else if (i_en && i_mode == 2'b10) begin
        m_q[k] <= {24'd0, i_D} & maskof(k);
        m_n[k] <= 0; m_v[k] <= 1'b0;
      end else if (i_en && i_mode == 2'b11) begin
        m_q[k] <= 32'd0; m_n[k] <= 0; m_v[k] <= 1'b0;
      end else begin
        m_v[k] <= 1'b0;
      end
    end
  end

  task automatic cmp(input int k, input logic [31:0] q, input logic [31:0] cnt,
                     input logic sd, input logic v);
    logic [31:0] mq;
    logic        esd;
    mq  = m_q[k];
    esd = mof(k) ? mq[0] : mq[wof(k) - 1];
    chk($sformatf("dut%0d_q", k),     q,            mq);
    chk($sformatf("dut%0d_cnt", k),   cnt,          32'(m_n[k] % wof(k)));
    chk($sformatf("dut%0d_sd", k),    {31'd0, sd},  {31'd0, esd});
    chk($sformatf("dut%0d_valid", k), {31'd0, v},   {31'd0, m_v[k]});
  endtask

  always @(negedge i_clk) begin
    if (chk_en) begin
      cmp(0, {24'd0, q0}, {28'd0, cnt0}, sd0, v0);
      cmp(1, {24'd0, q1}, {28'd0, cnt1}, sd1, v1);
      cmp(2, {27'd0, q2}, {29'd0, cnt2}, sd2, v2);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input logic en, input logic [1:0] mode, input logic sd, input logic [7:0] d);
    i_en = en; i_mode = mode; i_SD = sd; i_D = d;
    @(posedge i_clk);
    #1;
  endtask

  task automatic rst_tick();
    i_rst = 1'b0;
    tick(1'b1, 2'b01, 1'b1, 8'hFF);
    i_rst = 1'b1;
  endtask

  initial begin
    logic [7:0] stream;
    logic [7:0] a5;
    logic [7:0] frz_q;
    logic [3:0] frz_c;
    int         pulses;
    int         early;

    i_rst = 1'b0; i_en = 1'b0; i_mode = 2'b00; i_SD = 1'b0; i_D = 8'h00;
    rst_tick();
    chk_en = 1'b1;
    chk("reset_q0",     {24'd0, q0}, 32'd0);
    chk("reset_cnt0",   {28'd0, cnt0}, 32'd0);
    chk("reset_valid0", {31'd0, v0}, 32'd0);
    $display("T0 reset q0=%h q1=%h q2=%h", q0, q1, q2);

    // Scenario 1/2: bit stream 1,0,1,1,0,0,1,0
    stream = 8'b10110010;
    for (int i = 7; i >= 0; i--) tick(1'b1, 2'b01, stream[i], 8'h00);
    chk("s1_q0",     {24'd0, q0}, 32'hB2);
    chk("s1_valid0", {31'd0, v0}, 32'd1);
    chk("s1_cnt0",   {28'd0, cnt0}, 32'd0);
    chk("s2_q1",     {24'd0, q1}, 32'h4D);
    chk("s2_valid1", {31'd0, v1}, 32'd1);
    chk("s2_sd1",    {31'd0, sd1}, 32'd1);
    $display("T1 stream q0=%h q1=%h valid=%b%b", q0, q1, v0, v1);
    tick(1'b1, 2'b00, 1'b0, 8'h00);
    chk("s1_pulse_end", {31'd0, v0}, 32'd0);
    chk("s1_hold_q0",   {24'd0, q0}, 32'hB2);

    // Scenario 3: load A5 then shift out zeros
    a5 = 8'hA5;
    tick(1'b1, 2'b10, 1'b0, a5);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("s3_sd_%0d", k), {31'd0, sd0}, {31'd0, a5[7-k]});
      tick(1'b1, 2'b01, 1'b0, 8'h00);
    end
    chk("s3_q0_end",    {24'd0, q0}, 32'h00);
    chk("s3_valid_end", {31'd0, v0}, 32'd1);
    $display("T3 load/shift-out q0=%h valid=%b", q0, v0);

    // Scenario 4: partial word discarded by reset
    rst_tick();
    for (int i = 0; i < 5; i++) tick(1'b1, 2'b01, 1'b1, 8'h00);
    rst_tick();
    pulses = 0; early = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 2'b01, 1'b0, 8'h00);
      if (v0) begin
        pulses++;
        if (i != 7) early++;
      end
    end
    chk("s4_pulses",      32'(pulses), 32'd1);
    chk("s4_early_pulse", 32'(early), 32'd0);
    chk("s4_valid_last",  {31'd0, v0}, 32'd1);
    $display("T4 reset mid-word pulses=%0d", pulses);

    // Scenario 5: 24 shifts, 3-cycle stall after bit 4
    rst_tick();
    pulses = 0;
    frz_q = 8'h00; frz_c = 4'd0;
    for (int i = 0; i < 24; i++) begin
      if (i == 4) begin
        frz_q = q0; frz_c = cnt0;
        for (int s = 0; s < 3; s++) begin
          tick(1'b0, 2'b01, 1'b1, 8'h00);
          chk("s5_frozen_q",   {24'd0, q0}, {24'd0, frz_q});
          chk("s5_frozen_cnt", {28'd0, cnt0}, {28'd0, frz_c});
        end
      end
      tick(1'b1, 2'b01, (i % 3) == 0, 8'h00);
      if (v0) pulses++;
    end
    chk("s5_pulses", 32'(pulses), 32'd3);
    chk("s5_cnt4",   {28'd0, frz_c}, 32'd4);
    $display("T5 stall pulses=%0d", pulses);

    // Scenario 6: WIDTH=5 build, five ones then clear
    rst_tick();
    for (int i = 0; i < 5; i++) tick(1'b1, 2'b01, 1'b1, 8'h00);
    chk("s6_q2",     {27'd0, q2}, 32'h1F);
    chk("s6_valid2", {31'd0, v2}, 32'd1);
    tick(1'b1, 2'b11, 1'b1, 8'h00);
    chk("s6_clr_q2",   {27'd0, q2}, 32'd0);
    chk("s6_clr_cnt2", {29'd0, cnt2}, 32'd0);
    chk("s6_clr_v2",   {31'd0, v2}, 32'd0);
    $display("T6 width5 clear q2=%h cnt2=%0d", q2, cnt2);

    // Mixed directed sequence: modes, enables and a mid-run reset
    for (int i = 0; i < 60; i++) begin
      logic [1:0] md;
      case (i % 13)
        7:       md = 2'b00;
        9:       md = 2'b10;
        12:      md = 2'b11;
        default: md = 2'b01;
      endcase
      if (i == 31) i_rst = 1'b0;
      tick((i % 7) != 3, md, ((i * 5) % 3) == 1, 8'(i * 37));
      i_rst = 1'b1;
    end
    $display("T7 mixed q0=%h q1=%h q2=%h", q0, q1, q2);

    @(negedge i_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
